// File: rtl/sqr_wav_meas.sv
// sqr_wav_meas: measures the high and low widths of an incoming square wave
// in 100 ns ticks and publishes each completed period as one atomic pair.
`timescale 1ns/1ps

module sqr_wav_meas #(
    parameter int CLK_PER_TICK = 10,
    parameter int CNT_W        = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sqr_in,
    input  logic             clr,
    output logic [CNT_W-1:0] high_ticks,
    output logic [CNT_W-1:0] low_ticks,
    output logic             meas_valid,
    output logic             ovf
);

    localparam int              PW    = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0]   PLAST = PW'(CLK_PER_TICK - 1);
    localparam logic [CNT_W-1:0] WMAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_prev;
    logic                   rise, fall, edge_any;
    logic [PW-1:0]          presc;
    logic                   tick;
    logic [CNT_W-1:0]       wcnt;
    logic [CNT_W-1:0]       cap;
    logic [CNT_W-1:0]       high_buf;
    logic                   have_high;
    logic                   load_high, publish, set_have, clr_have;

    // Resynchronise the asynchronous input and keep the previous level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            s_prev <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], sqr_in};
            s_prev <= s;
        end
    end

    assign s        = sync[SYNC_STAGES-1];
    assign rise     = s & ~s_prev;
    assign fall     = ~s & s_prev;
    assign edge_any = rise | fall;
    assign tick     = (presc == PLAST);

    // Width seen at an edge counts the tick completing in this very cycle, so an
    // exact k-tick level reports k; never wraps past the saturation value.
    assign cap = (tick && (wcnt != WMAX)) ? wcnt + 1'b1 : wcnt;

    // Tick prescaler and saturating width counter, both realigned on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            wcnt  <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            presc <= '0;
            wcnt  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (edge_any) begin
                presc <= '0;
                wcnt  <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && (wcnt != WMAX))
                    wcnt <= wcnt + 1'b1;
            end
            // Sticky: the level (or its captured width) has hit the ceiling.
            if (tick && (wcnt == WMAX - 1'b1))
                ovf <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state and datapath strobes; clr overrides every event in its cycle.
    always_comb begin
        state_nxt = state;
        load_high = 1'b0;
        publish   = 1'b0;
        set_have  = 1'b0;
        clr_have  = 1'b0;
        case (state)
            IDLE: begin
                // Whatever level we woke up in is partial and is thrown away.
                if (rise) begin
                    state_nxt = MEAS_HIGH;
                end else if (fall) begin
                    state_nxt = MEAS_LOW;
                    clr_have  = 1'b1;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    load_high = 1'b1;
                    set_have  = 1'b1;
                    state_nxt = MEAS_LOW;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    publish   = have_high;
                    state_nxt = MEAS_HIGH;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) begin
            state_nxt = IDLE;
            load_high = 1'b0;
            publish   = 1'b0;
            set_have  = 1'b0;
            clr_have  = 1'b1;
        end
    end

    // Hold the high width until its low partner completes, then publish both together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_buf   <= '0;
            have_high  <= 1'b0;
            high_ticks <= '0;
            low_ticks  <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= publish;
            if (clr) begin
                high_buf   <= '0;
                have_high  <= 1'b0;
                high_ticks <= '0;
                low_ticks  <= '0;
            end else begin
                if (load_high)
                    high_buf <= cap;
                if (set_have)
                    have_high <= 1'b1;
                else if (clr_have)
                    have_high <= 1'b0;
                if (publish) begin
                    high_ticks <= high_buf;
                    low_ticks  <= cap;
                end
            end
        end
    end

endmodule

// File: tb/tb_sqr_wav_meas.sv
// tb_sqr_wav_meas: directed and random square waves against a level-list model.
`timescale 1ns/1ps

module tb_sqr_wav_meas;

    localparam int CPT = 10;
    localparam int CW  = 8;
    localparam int SS  = 2;
    localparam int MX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sqr_in;
    logic          clr;
    logic [CW-1:0] high_ticks;
    logic [CW-1:0] low_ticks;
    logic          meas_valid;
    logic          ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] gotq[$];
    logic [15:0] expq[$];
    int          stq[$];

    // Model: current level value/length, length of last high, and whether that
    // high started on a rise the DUT was allowed to see.
    bit m_v;
    int m_len;
    int m_hlen;
    bit m_hfull;

    sqr_wav_meas #(
        .CLK_PER_TICK(CPT),
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sqr_in    (sqr_in),
        .clr       (clr),
        .high_ticks(high_ticks),
        .low_ticks (low_ticks),
        .meas_valid(meas_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Collect every published pair with its cycle stamp.
    always @(negedge clk) begin
        if (reset_n && meas_valid) begin
            gotq.push_back({high_ticks, low_ticks});
            stq.push_back(cyc);
        end
    end

    function automatic logic [7:0] w(input int n);
        return (n / CPT > MX) ? 8'(MX) : 8'(n / CPT);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a level for n clocks; a change of value closes the previous level in the model.
    task automatic lvl(input bit v, input int n);
        if (v != m_v) begin
            if (v) begin
                if (m_hfull) expq.push_back({w(m_hlen), w(m_len)});
                m_hfull = 1'b1;
            end else begin
                m_hlen = m_len;
            end
            m_v   = v;
            m_len = 0;
        end
        sqr_in = v;
        m_len += n;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic period(input int h, input int l);
        lvl(1'b1, h);
        lvl(1'b0, l);
    endtask

    task automatic drain(input string tag);
        chk($sformatf("%s_count", tag), gotq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < gotq.size())
                chk($sformatf("%s_pair%0d", tag, i), gotq[i], expq[i]);
        end
        gotq.delete();
        expq.delete();
        stq.delete();
    endtask

    task automatic spacing(input string tag, input int p);
        for (int i = 1; i < stq.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), stq[i] - stq[i-1], p);
    endtask

    initial begin
        reset_n = 1'b0;
        sqr_in  = 1'b0;
        clr     = 1'b0;
        m_v = 1'b0; m_len = 0; m_hlen = 0; m_hfull = 1'b0;
        #1;
        chk("rst_high", high_ticks, 0);
        chk("rst_low", low_ticks, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_ovf", ovf, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Generator at high_m=3, low_n=5.
        lvl(1'b0, 20);
        for (int i = 0; i < 5; i++) period(30, 50);
        lvl(1'b1, 30);
        spacing("p35", 80);
        chk("p35_ovf", ovf, 0);
        drain("p35");

        // Switched to m=1, n=1.
        lvl(1'b0, 50);
        for (int i = 0; i < 6; i++) period(10, 10);
        lvl(1'b1, 10);
        spacing("p11", 20);
        drain("p11");

        // Non-multiple widths, plus exact latency from the sampled rise.
        lvl(1'b0, 10);
        lvl(1'b1, 25);
        lvl(1'b0, 10);
        lvl(1'b1, 1);
        @(negedge clk) chk("lat_c1", meas_valid, 0);
        @(negedge clk) chk("lat_c2", meas_valid, 0);
        @(negedge clk) chk("lat_c3", meas_valid, 1);
        chk("lat_high", high_ticks, 2);
        chk("lat_low", low_ticks, 1);
        @(posedge clk);
        #1;
        m_len += 3;
        lvl(1'b1, 21);
        lvl(1'b0, 25);
        drain("trunc");

        // Random widths including single-clock glitches.
        for (int i = 0; i < 20; i++)
            period(int'($urandom_range(1, 70)), int'($urandom_range(1, 70)));
        lvl(1'b1, 20);
        chk("rand_ovf", ovf, 0);
        drain("rand");

        // Constant high long enough to saturate.
        lvl(1'b0, 30);
        lvl(1'b1, 2500);
        chk("sat_ovf_pre", ovf, 0);
        lvl(1'b1, 500);
        chk("sat_ovf_post", ovf, 1);
        lvl(1'b0, 40);
        lvl(1'b1, 20);
        chk("sat_high", high_ticks, MX);
        chk("sat_ovf_sticky", ovf, 1);
        drain("sat");

        // clr landing exactly on a completing rise.
        lvl(1'b0, 50);
        sqr_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr_valid", meas_valid, 0);
        chk("clr_high", high_ticks, 0);
        chk("clr_low", low_ticks, 0);
        chk("clr_ovf", ovf, 0);
        m_v = 1'b1; m_len = 3; m_hfull = 1'b0;
        lvl(1'b1, 27);
        lvl(1'b0, 50);
        lvl(1'b1, 30);
        lvl(1'b0, 50);
        lvl(1'b1, 10);
        drain("clr");

        // Reset mid-high, released while low.
        lvl(1'b1, 15);
        reset_n = 1'b0;
        sqr_in  = 1'b0;
        #1;
        chk("mid_rst_high", high_ticks, 0);
        chk("mid_rst_low", low_ticks, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        m_v = 1'b0; m_len = 0; m_hfull = 1'b0;
        lvl(1'b0, 20);
        lvl(1'b1, 30);
        lvl(1'b0, 40);
        drain("rst_none");
        lvl(1'b1, 20);
        lvl(1'b0, 20);
        drain("rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
